// File: rtl/rr_grant_mux_pkg.sv
// Shared types and helpers for the round-robin grant mux.
package rr_grant_mux_pkg;

    // Widest source count the onehot helper supports; callers size-cast the result.
    localparam int ONEHOT_MAX = 64;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // One-hot vector with bit idx set; callers cast down to their own width.
    function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx);
        return ONEHOT_MAX'(1) << idx;
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Lowest-set-bit encoder: binary index of the lowest set bit plus an any-set flag.
module onehot_to_bin #(
    parameter  int N  = 8,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    output logic [SW-1:0] idx,
    output logic          any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = SW'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/rr_grant_mux.sv
// Packet-level grant mux behind an external round-robin arbiter: steers the
// arbiter's request so grants only move between packets and when the output
// register can take a beat, then registers the winning beat.
module rr_grant_mux
    import rr_grant_mux_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int DW = 32,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  in_valid,
    input  logic [DW-1:0] in_data [N],
    input  logic [N-1:0]  in_last,
    output logic [N-1:0]  in_ready,
    output logic [N-1:0]  arb_req,
    input  logic [N-1:0]  arb_gnt,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [SW-1:0] out_src,
    input  logic          out_ready
);

    state_t        state_reg, state_next;
    logic [SW-1:0] lock_src_reg, lock_src_next;
    logic [SW-1:0] last_src_reg, last_src_next;
    logic          out_valid_reg, out_valid_next;
    logic [DW-1:0] out_data_reg, out_data_next;
    logic          out_last_reg, out_last_next;
    logic [SW-1:0] out_src_reg, out_src_next;

    logic          can_accept;
    logic [N-1:0]  lock_onehot;
    logic [N-1:0]  last_onehot;
    logic [N-1:0]  w_onehot;
    logic [N-1:0]  sel_mask;
    logic [SW-1:0] w;
    logic          gnt_any;
    logic          capture;

    // A non-one-hot grant resolves to its lowest set bit.
    onehot_to_bin #(.N(N)) u_gnt_enc (
        .vec (arb_gnt),
        .idx (w),
        .any (gnt_any)
    );

    assign can_accept  = !out_valid_reg || out_ready;
    assign lock_onehot = N'(onehot(32'(lock_src_reg)));
    assign last_onehot = N'(onehot(32'(last_src_reg)));
    assign w_onehot    = N'(onehot(32'(w)));
    assign sel_mask    = (state_reg == LOCK) ? lock_onehot : {N{1'b1}};
    assign capture     = can_accept && gnt_any && in_valid[w] && sel_mask[w];

    // Request steering: pin the arbiter to the packet owner while locked, and to
    // the previous winner while stalled, so its pointer only moves on a real capture.
    always_comb begin
        arb_req = '0;
        if (state_reg == LOCK) begin
            arb_req = lock_onehot;
        end else if (can_accept) begin
            arb_req = in_valid;
        end else begin
            arb_req = last_onehot;
        end
    end

    assign in_ready = capture ? w_onehot : '0;

    // Next-state: load the granted beat on capture, otherwise drain on out_ready.
    always_comb begin
        state_next     = state_reg;
        lock_src_next  = lock_src_reg;
        last_src_next  = last_src_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;
        out_src_next   = out_src_reg;
        if (capture) begin
            out_valid_next = 1'b1;
            out_data_next  = in_data[w];
            out_last_next  = in_last[w];
            out_src_next   = w;
            last_src_next  = w;
            if (state_reg == IDLE && !in_last[w]) begin
                state_next    = LOCK;
                lock_src_next = w;
            end else if (state_reg == LOCK && in_last[w]) begin
                state_next = IDLE;
            end
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    // State and output registers; reset drops any beat in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lock_src_reg  <= '0;
            last_src_reg  <= SW'(N - 1);
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_src_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            lock_src_reg  <= lock_src_next;
            last_src_reg  <= last_src_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_last_reg  <= out_last_next;
            out_src_reg   <= out_src_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign out_src   = out_src_reg;

`ifndef SYNTHESIS
    a_in_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(in_ready));
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(arb_gnt));
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> ($stable(out_valid) && $stable(out_data)
                                       && $stable(out_last) && $stable(out_src)));
    a_lock_src: assert property (@(posedge clk) disable iff (!rst_n)
        (state_reg == LOCK && capture) |-> (w == lock_src_reg));
`endif

endmodule

// File: tb/tb_rr_grant_mux.sv
// Testbench for rr_grant_mux with a behavioural round-robin arbiter in the loop.
module tb_rr_grant_mux;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  in_valid;
    logic [DW-1:0] in_data [N];
    logic [N-1:0]  in_last;
    logic [N-1:0]  in_ready;
    logic [N-1:0]  arb_req;
    logic [N-1:0]  arb_gnt;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [SW-1:0] out_src;
    logic          out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rr_grant_mux #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .arb_req   (arb_req),
        .arb_gnt   (arb_gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    // Round-robin arbiter: first requester after the last grant, pointer moves on any grant.
    logic [SW-1:0] arb_ptr;
    logic          arb_found;
    always_comb begin
        arb_gnt   = '0;
        arb_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!arb_found && arb_req[(int'(arb_ptr) + k) % N]) begin
                arb_gnt[(int'(arb_ptr) + k) % N] = 1'b1;
                arb_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_ptr <= SW'(N - 1);
        end else begin
            for (int k = 0; k < N; k++) begin
                if (arb_gnt[k]) arb_ptr <= SW'(k);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] dir_data(input int s);
        return 32'hC0DE_0000 + 32'(s);
    endfunction

    // Directed vector: inputs for one cycle, combinational expectations, then registered ones.
    typedef struct packed {
        logic [N-1:0]  valid;
        logic [N-1:0]  last;
        logic          ordy;
        logic [N-1:0]  exp_req;
        logic [N-1:0]  exp_rdy;
        logic          exp_ov;
        logic [SW-1:0] exp_src;
        logic          exp_olast;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [N-1:0] v, input logic [N-1:0] l, input logic r,
                       input logic [N-1:0] er, input logic [N-1:0] ey,
                       input logic eo, input logic [SW-1:0] es, input logic el);
        vec_t t;
        t = '{valid: v, last: l, ordy: r, exp_req: er, exp_rdy: ey,
              exp_ov: eo, exp_src: es, exp_olast: el};
        vq.push_back(t);
    endtask

    // Random-phase reference model: packet owner, last winner and the output slot.
    logic        m_ov, m_last, m_locked;
    logic [DW-1:0] m_data;
    int          m_src, m_owner, m_lastsrc;
    int          beats_left [N];
    int          seq [N];
    int          wait_cnt [N];
    logic        mid_pkt;
    int          mid_src;

    task automatic drive_sources(input logic [N-1:0] acc);
        for (int s = 0; s < N; s++) begin
            if (acc[s]) begin
                seq[s]++;
                beats_left[s]--;
                in_valid[s] = 1'b0;
            end
            if (beats_left[s] == 0) beats_left[s] = $urandom_range(1, 4);
            if (!in_valid[s]) in_valid[s] = ($urandom_range(0, 3) != 0);
            in_last[s] = (beats_left[s] == 1);
            in_data[s] = {8'(s), 24'(seq[s])};
        end
        out_ready = ($urandom_range(0, 9) < 7);
    endtask

    initial begin
        vec_t v;
        int cap;
        logic can;
        logic [N-1:0] exp_rdy;
        int w;

        rst_n     = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b1;
        for (int s = 0; s < N; s++) in_data[s] = dir_data(s);

        // Test 1: all single-beat, rotate 0..3 then wrap
        add(4'b1111, 4'b1111, 1, 4'b1111, 4'b0001, 1, 0, 1);
        add(4'b1111, 4'b1111, 1, 4'b1111, 4'b0010, 1, 1, 1);
        add(4'b1111, 4'b1111, 1, 4'b1111, 4'b0100, 1, 2, 1);
        add(4'b1111, 4'b1111, 1, 4'b1111, 4'b1000, 1, 3, 1);
        add(4'b1111, 4'b1111, 1, 4'b1111, 4'b0001, 1, 0, 1);
        // Test 3: stall holds src0 and pins the arbiter, release continues at src1
        for (int i = 0; i < 5; i++) add(4'b1111, 4'b1111, 0, 4'b0001, 4'b0000, 1, 0, 1);
        add(4'b1111, 4'b1111, 1, 4'b1111, 4'b0010, 1, 1, 1);
        add(4'b1111, 4'b1111, 1, 4'b1111, 4'b0100, 1, 2, 1);
        // Test 2: src1 3-beat packet locks out src2
        add(4'b0110, 4'b0100, 1, 4'b0110, 4'b0010, 1, 1, 0);
        add(4'b0110, 4'b0100, 1, 4'b0010, 4'b0010, 1, 1, 0);
        add(4'b0110, 4'b0110, 1, 4'b0010, 4'b0010, 1, 1, 1);
        add(4'b0100, 4'b0100, 1, 4'b0100, 4'b0100, 1, 2, 1);
        // Test 4: src3 locked with a 2-cycle bubble, src0 waits
        add(4'b1001, 4'b0001, 1, 4'b1001, 4'b1000, 1, 3, 0);
        add(4'b0001, 4'b0001, 1, 4'b1000, 4'b0000, 0, 0, 0);
        add(4'b0001, 4'b0001, 1, 4'b1000, 4'b0000, 0, 0, 0);
        add(4'b1001, 4'b1001, 1, 4'b1000, 4'b1000, 1, 3, 1);
        add(4'b0001, 4'b0001, 1, 4'b0001, 4'b0001, 1, 0, 1);
        // Idle: nothing valid, output drains
        add(4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset out_data", 64'(out_data), 64'(0));
        check("reset out_last", 64'(out_last), 64'(0));
        check("reset out_src", 64'(out_src), 64'(0));
        check("reset arb_req", 64'(arb_req), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            in_valid  = v.valid;
            in_last   = v.last;
            out_ready = v.ordy;
            @(negedge clk);
            check($sformatf("vec%0d arb_req", i), 64'(arb_req), 64'(v.exp_req));
            check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(v.exp_rdy));
            @(posedge clk); #1;
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(v.exp_ov));
            if (v.exp_ov) begin
                check($sformatf("vec%0d out_src", i), 64'(out_src), 64'(v.exp_src));
                check($sformatf("vec%0d out_last", i), 64'(out_last), 64'(v.exp_olast));
                check($sformatf("vec%0d out_data", i), 64'(out_data), 64'(dir_data(int'(v.exp_src))));
            end
            $display("vec %0d: valid=%b last=%b ordy=%b -> out_valid=%b out_src=%0d out_last=%b",
                     i, v.valid, v.last, v.ordy, out_valid, out_src, out_last);
        end

        // Test 5: async reset mid-packet drops the beat, then a fresh grant to src2
        in_valid = 4'b0010; in_last = 4'b0000; out_ready = 1'b1;
        @(negedge clk);
        check("t5 lock in_ready", 64'(in_ready), 64'(4'b0010));
        @(posedge clk); #1;
        check("t5 lock out_valid", 64'(out_valid), 64'(1));
        check("t5 lock out_src", 64'(out_src), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        check("t5 async out_valid", 64'(out_valid), 64'(0));
        check("t5 async out_src", 64'(out_src), 64'(0));
        check("t5 async out_data", 64'(out_data), 64'(0));
        in_valid = 4'b0100; in_last = 4'b0100;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5 post arb_req", 64'(arb_req), 64'(4'b0100));
        check("t5 post in_ready", 64'(in_ready), 64'(4'b0100));
        @(posedge clk); #1;
        check("t5 post out_valid", 64'(out_valid), 64'(1));
        check("t5 post out_src", 64'(out_src), 64'(2));
        check("t5 post out_data", 64'(out_data), 64'(dir_data(2)));
        $display("reset sequence: out_valid=%b out_src=%0d", out_valid, out_src);

        // Test 6: randomized traffic against the reference model
        out_ready = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ov = 1'b0; m_last = 1'b0; m_data = '0; m_src = 0;
        m_locked = 1'b0; m_owner = 0; m_lastsrc = N - 1;
        mid_pkt = 1'b0; mid_src = 0;
        for (int s = 0; s < N; s++) begin
            beats_left[s] = 0; seq[s] = 0; wait_cnt[s] = 0;
        end
        drive_sources('0);

        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            can = !m_ov || out_ready;
            cap = -1;
            if (m_locked) begin
                if (can && in_valid[m_owner]) cap = m_owner;
            end else if (can) begin
                for (int k = 1; k <= N; k++) begin
                    if (cap < 0 && in_valid[(m_lastsrc + k) % N]) cap = (m_lastsrc + k) % N;
                end
            end
            exp_rdy = (cap >= 0) ? N'(1 << cap) : '0;
            check("rand in_ready", 64'(in_ready), 64'(exp_rdy));

            // Packet-level ordering and fairness observed on the DUT handshake
            if (in_ready != '0) begin
                w = 0;
                for (int s = N - 1; s >= 0; s--) if (in_ready[s]) w = s;
                if (mid_pkt) begin
                    check("rand no_interleave", 64'(w), 64'(mid_src));
                end else begin
                    check("rand fair_wait", 64'(wait_cnt[w] > N - 1), 64'(0));
                    for (int s = 0; s < N; s++) if (s != w && in_valid[s]) wait_cnt[s]++;
                    wait_cnt[w] = 0;
                end
                mid_pkt = !in_last[w];
                mid_src = w;
            end

            @(posedge clk); #1;
            if (cap >= 0) begin
                m_ov = 1'b1; m_data = in_data[cap]; m_last = in_last[cap];
                m_src = cap; m_lastsrc = cap;
                if (!m_locked && !in_last[cap]) begin
                    m_locked = 1'b1; m_owner = cap;
                end else if (m_locked && in_last[cap]) begin
                    m_locked = 1'b0;
                end
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
            check("rand out_valid", 64'(out_valid), 64'(m_ov));
            if (m_ov) begin
                check("rand out_src", 64'(out_src), 64'(m_src));
                check("rand out_data", 64'(out_data), 64'(m_data));
                check("rand out_last", 64'(out_last), 64'(m_last));
            end
            if (cyc % 2500 == 2499) $display("random: %0d cycles done", cyc + 1);
            drive_sources(exp_rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_grant_mux.md
Name: rr_grant_mux

Overview:
- Data-path stage directly downstream of rr_arbiter: consumes the one-hot gnt, selects the winning source's beat and registers it onto a single valid/ready output.
- Drives rr_arbiter's req input, so the arbiter's mask never advances while the output is stalled or a multi-beat packet is in progress.
- Packet-level round-robin among N streaming sources; one beat per cycle throughput.

Parameters:
- N, 8, number of sources (matches rr_arbiter N).
- DW, 32, data width per beat.
- SW, $clog2(N), width of source index (derived, not overridable).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-source beat valid.
- in_data  input  N x DW  per-source beat data (unpacked array [N]).
- in_last  input  N  per-source last beat of packet.
- in_ready  output  N  per-source accept; at most one bit set.
- arb_req  output  N  to rr_arbiter req.
- arb_gnt  input  N  from rr_arbiter gnt, one-hot or zero, combinational from arb_req.
- out_valid  output  1  output beat valid.
- out_data  output  DW  output beat data.
- out_last  output  1  output last flag.
- out_src  output  SW  source index of output beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset: out_valid=0, out_data=0, out_last=0, out_src=0, state=IDLE, lock_src=0, last_src=N-1. in_ready and arb_req follow from the reset state.
- can_accept = !out_valid || out_ready (output register empty or draining this cycle).
- FSM states: IDLE (between packets), LOCK (mid-packet on lock_src).
- arb_req in IDLE with can_accept: arb_req = in_valid.
- arb_req in IDLE without can_accept: arb_req = onehot(last_src). The arbiter regrants last_src and its mask is unchanged, so fairness is preserved across stalls.
- arb_req in LOCK: arb_req = onehot(lock_src), always.
- Capture condition: can_accept && (arb_gnt & in_valid & sel_mask) != 0. sel_mask = all-ones in IDLE, onehot(lock_src) in LOCK.
- In IDLE without can_accept, arb_gnt is ignored.
- On capture, with w = index of arb_gnt:
  - in_ready[w]=1 (combinational, same cycle).
  - out_valid<=1, out_data<=in_data[w], out_last<=in_last[w], out_src<=w, last_src<=w.
- FSM transitions:
  - IDLE -> LOCK (lock_src<=w) on capture with in_last[w]=0.
  - LOCK -> IDLE on capture with in_last=1.
  - Single-beat packets stay in IDLE.
- No capture but out_ready=1: out_valid<=0; data fields hold.
- in_ready = 0 whenever there is no capture.
- Latency: in_valid -> out_valid is 1 cycle. Back-to-back beats are accepted every cycle while out_ready=1.
- LOCK with in_valid[lock_src]=0 (bubble): no capture and no switch to other sources; LOCK holds indefinitely.
- Simultaneous out_ready and capture: old beat leaves, new beat loads in the same edge.
- arb_gnt bit whose in_valid is low: treated as no capture.
- arb_gnt not one-hot: assertion failure in simulation. RTL uses the lowest set bit.
- Reset mid-packet: returns to IDLE and drops the output beat. The upstream partial packet is the source's responsibility.
- Assertions:
  - $onehot0(in_ready).
  - out_valid && !out_ready |=> stable out_*.
  - LOCK implies out_src==lock_src on every capture.

Decomposition:
- Package rr_grant_mux_pkg:
  - typedef enum logic {IDLE, LOCK} state_t.
  - function onehot(idx) returning logic [N-1:0] (parameterised via function argument width).
- Sub-module onehot_to_bin #(N): lowest-set-bit index plus any-set flag. Used for w.
- The top instantiates no arbiter; integration ties arb_req/arb_gnt to an rr_arbiter of the same N.

Test Plan:
1. N=4, all sources single-beat, in_valid=4'b1111 constant, out_ready=1 -> out_src sequence 0,1,2,3,0,...; one beat per cycle after 1-cycle latency.
2. Src1 sends 3-beat packet (last on beat 3), src2 valid throughout -> out_src=1,1,1 then 2; src2 in_ready=0 during LOCK.
3. in_valid=4'b1111, out_ready held 0 for 5 cycles after first beat (src0) -> out_* stable; arb_req=4'b0001; on release next beats src1, src2 (no restart at 0).
4. Src3 in LOCK with a 2-cycle in_valid[3]=0 bubble, src0 valid -> no src0 beat until src3 last accepted; out_valid drops during bubble.
5. Reset asserted mid-LOCK with out_valid=1 -> out_valid=0 immediately (async); after release, in_valid=4'b0100 -> out_src=2 first.
6. Random in_valid/in_last/out_ready for 10k cycles, scoreboard per source -> no beat lost or reordered; no interleaving within a packet; max wait per packet ≤ (N-1) packets.
